// File: rtl/i2c_iobuf_pkg.sv
// Shared constants and helpers for the I2C pad conditioner.
// Holds the idle line level and the enable-to-filtered-view alignment depth.
package i2c_iobuf_pkg;

    localparam logic I2C_IDLE = 1'b1;

    // Cycles from a pad transition to the filtered line value.
    function automatic int dly(input int sync_stages, input int filt_len);
        return sync_stages + filt_len;
    endfunction

endpackage

// File: rtl/i2c_line_filt.sv
// One I2C line: synchroniser chain followed by a stability filter.
// The filtered output only follows the synced value after FILT_LEN consecutive differing cycles.
module i2c_line_filt
    import i2c_iobuf_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pad_raw,
    output logic filt
);

    localparam int CW = $clog2(FILT_LEN + 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [CW-1:0]          cnt_reg;
    logic [CW-1:0]          cnt_next;
    logic                   filt_reg;
    logic                   sync_out;

    assign sync_out = sync_reg[SYNC_STAGES-1];
    assign cnt_next = cnt_reg + CW'(1);
    assign filt     = filt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= {SYNC_STAGES{I2C_IDLE}};
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], pad_raw};
        end
    end

    // The counter clears in the same cycle the output flips, so it never holds FILT_LEN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg  <= '0;
            filt_reg <= I2C_IDLE;
        end else if (sync_out == filt_reg) begin
            cnt_reg <= '0;
        end else if (cnt_next == CW'(FILT_LEN)) begin
            cnt_reg  <= '0;
            filt_reg <= sync_out;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/i2c_iobuf_cond.sv
// Multi-channel open-drain I2C pad conditioner with START/STOP/busy/stretch reporting.
// Arbitration-loss detection is present only when I2C_IOBUF_ARB_DET_EN is defined.
module i2c_iobuf_cond
    import i2c_iobuf_pkg::*;
#(
    parameter int N_CH        = 2,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] scl_e,
    input  logic [N_CH-1:0] sda_e,
    inout  wire  [N_CH-1:0] scl,
    inout  wire  [N_CH-1:0] sda,
    output logic [N_CH-1:0] scl_i,
    output logic [N_CH-1:0] sda_i,
    output logic [N_CH-1:0] start_p,
    output logic [N_CH-1:0] stop_p,
    output logic [N_CH-1:0] busy,
    output logic [N_CH-1:0] stretch,
    output logic [N_CH-1:0] arb_lost_p
);

    localparam int D = dly(SYNC_STAGES, FILT_LEN);

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic         scl_raw;
        logic         sda_raw;
        logic [D-1:0] scl_dly_reg;
        logic         scl_q_reg;
        logic         sda_q_reg;
        logic         busy_reg;
        logic         start_reg;
        logic         stop_reg;
        logic         scl_high;
        logic         start_cond;
        logic         stop_cond;

        assign scl[gi] = scl_e[gi] ? 1'b0 : 1'bz;
        assign sda[gi] = sda_e[gi] ? 1'b0 : 1'bz;

        // Anything other than a solid 0 on the pad (z, x) reads as the idle level.
        assign scl_raw = (scl[gi] === 1'b0) ? 1'b0 : I2C_IDLE;
        assign sda_raw = (sda[gi] === 1'b0) ? 1'b0 : I2C_IDLE;

        i2c_line_filt #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_LEN    (FILT_LEN)
        ) u_scl_filt (
            .clk     (clk),
            .rst_n   (rst_n),
            .pad_raw (scl_raw),
            .filt    (scl_i[gi])
        );

        i2c_line_filt #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_LEN    (FILT_LEN)
        ) u_sda_filt (
            .clk     (clk),
            .rst_n   (rst_n),
            .pad_raw (sda_raw),
            .filt    (sda_i[gi])
        );

        // Requiring SCL stable high rejects events when both lines move together.
        assign scl_high   = scl_q_reg & scl_i[gi];
        assign start_cond = scl_high & sda_q_reg & !sda_i[gi];
        assign stop_cond  = scl_high & !sda_q_reg & sda_i[gi];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                scl_q_reg   <= I2C_IDLE;
                sda_q_reg   <= I2C_IDLE;
                busy_reg    <= 1'b0;
                start_reg   <= 1'b0;
                stop_reg    <= 1'b0;
                scl_dly_reg <= '0;
            end else begin
                scl_q_reg   <= scl_i[gi];
                sda_q_reg   <= sda_i[gi];
                start_reg   <= start_cond;
                stop_reg    <= stop_cond;
                scl_dly_reg <= {scl_dly_reg[D-2:0], scl_e[gi]};
                if (start_cond) begin
                    busy_reg <= 1'b1;
                end else if (stop_cond) begin
                    busy_reg <= 1'b0;
                end
            end
        end

        assign start_p[gi] = start_reg;
        assign stop_p[gi]  = stop_reg;
        assign busy[gi]    = busy_reg;
        assign stretch[gi] = !scl_dly_reg[D-1] & !scl_i[gi];

`ifdef I2C_IOBUF_ARB_DET_EN
        logic [D-1:0] sda_dly_reg;
        logic         arb_reg;
        logic         arb_done_reg;
        logic         arb_cond;

        // We released SDA yet see it low while SCL is high: another master won.
        assign arb_cond = !sda_dly_reg[D-1] & !sda_i[gi] & scl_high & busy_reg & !arb_done_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sda_dly_reg  <= '0;
                arb_reg      <= 1'b0;
                arb_done_reg <= 1'b0;
            end else begin
                sda_dly_reg <= {sda_dly_reg[D-2:0], sda_e[gi]};
                arb_reg     <= arb_cond;
                if (scl_q_reg & !scl_i[gi]) begin
                    arb_done_reg <= 1'b0;
                end else if (arb_cond) begin
                    arb_done_reg <= 1'b1;
                end
            end
        end

        assign arb_lost_p[gi] = arb_reg;
`else
        assign arb_lost_p[gi] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_i2c_iobuf_cond.sv
// Scoreboard bench for i2c_iobuf_cond: stimulus pushes expected line events with their
// cycle numbers, a negedge monitor pops and compares every event the DUT shows.
module tb_i2c_iobuf_cond;

    localparam int N_CH = 2;
    localparam int K_SCL = 0, K_SDA = 1, K_START = 2, K_STOP = 3;
    localparam int K_BUSY = 4, K_STR = 5, K_ARB = 6;

    typedef struct {
        int   kind;
        int   ch;
        logic val;
        int   cyc;
    } ev_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N_CH-1:0] scl_e, sda_e;
    logic [N_CH-1:0] tb_scl_low, tb_sda_low;
    wire  [N_CH-1:0] scl_net, sda_net;
    logic [N_CH-1:0] scl_i, sda_i, start_p, stop_p, busy, stretch, arb_lost_p;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic mon_en = 1'b0;
    ev_t  exp_q[$];
    logic [N_CH-1:0] prev_scl, prev_sda, prev_busy, prev_str;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_pad
        pullup pu_scl (scl_net[gi]);
        pullup pu_sda (sda_net[gi]);
        assign scl_net[gi] = tb_scl_low[gi] ? 1'b0 : 1'bz;
        assign sda_net[gi] = tb_sda_low[gi] ? 1'b0 : 1'bz;
    end

    i2c_iobuf_cond #(
        .N_CH        (N_CH),
        .SYNC_STAGES (2),
        .FILT_LEN    (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .scl_e      (scl_e),
        .sda_e      (sda_e),
        .scl        (scl_net),
        .sda        (sda_net),
        .scl_i      (scl_i),
        .sda_i      (sda_i),
        .start_p    (start_p),
        .stop_p     (stop_p),
        .busy       (busy),
        .stretch    (stretch),
        .arb_lost_p (arb_lost_p)
    );

    function automatic string kname(input int k);
        case (k)
            K_SCL:   return "scl_i";
            K_SDA:   return "sda_i";
            K_START: return "start_p";
            K_STOP:  return "stop_p";
            K_BUSY:  return "busy";
            K_STR:   return "stretch";
            default: return "arb_lost_p";
        endcase
    endfunction

    function automatic logic cur_of(input int k, input int c);
        case (k)
            K_SCL:   return scl_i[c];
            K_SDA:   return sda_i[c];
            K_START: return start_p[c];
            K_STOP:  return stop_p[c];
            K_BUSY:  return busy[c];
            K_STR:   return stretch[c];
            default: return arb_lost_p[c];
        endcase
    endfunction

    function automatic logic prev_of(input int k, input int c);
        case (k)
            K_SCL:   return prev_scl[c];
            K_SDA:   return prev_sda[c];
            K_BUSY:  return prev_busy[c];
            K_STR:   return prev_str[c];
            default: return 1'b0;
        endcase
    endfunction

    task automatic push(input int k, input int c, input logic v, input int at);
        ev_t e;
        e.kind = k;
        e.ch   = c;
        e.val  = v;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    task automatic check_event(input int k, input int c, input logic v);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected %s ch%0d: got val=%0b at cyc %0d, required no event",
                     kname(k), c, v, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.ch != c || e.val != v || e.cyc != cyc) begin
                errors++;
                $display("FAIL %s ch%0d: got %s ch%0d val=%0b cyc=%0d, required %s ch%0d val=%0b cyc=%0d",
                         kname(e.kind), e.ch, kname(k), c, v, cyc, kname(e.kind), e.ch, e.val, e.cyc);
            end else begin
                $display("ok   %s ch%0d val=%0b cyc=%0d", kname(k), c, v, cyc);
            end
        end
    endtask

    // Monitor: any level change or pulse is an event, reported in (kind, channel) order.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int k = 0; k < 7; k++) begin
                for (int c = 0; c < N_CH; c++) begin
                    logic now_v;
                    logic hit;
                    now_v = cur_of(k, c);
                    if (k == K_START || k == K_STOP || k == K_ARB) hit = now_v;
                    else hit = (now_v != prev_of(k, c));
                    if (hit) check_event(k, c, now_v);
                end
            end
        end
        prev_scl  = scl_i;
        prev_sda  = sda_i;
        prev_busy = busy;
        prev_str  = stretch;
    end

    task automatic chk(input string nm, input logic [N_CH-1:0] got, input logic [N_CH-1:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %b, required %b", nm, got, req);
        end else begin
            $display("ok   %s = %b", nm, got);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int k;
        rst_n      = 1'b0;
        scl_e      = '1;
        sda_e      = '1;
        tb_scl_low = '0;
        tb_sda_low = '0;
        wait_cyc(4);
        chk("rst_scl_pad", scl_net, 2'b00);
        chk("rst_sda_pad", sda_net, 2'b00);
        chk("rst_scl_i", scl_i, 2'b11);
        chk("rst_sda_i", sda_i, 2'b11);
        chk("rst_busy", busy, 2'b00);
        chk("rst_stretch", stretch, 2'b00);
        chk("rst_start_p", start_p, 2'b00);
        chk("rst_stop_p", stop_p, 2'b00);
        chk("rst_arb_lost_p", arb_lost_p, 2'b00);

        rst_n  = 1'b1;
        scl_e  = '0;
        sda_e  = '0;
        mon_en = 1'b1;
        wait_cyc(8);

        // Hold SCL low so SDA glitches cannot form START/STOP.
        k = cyc; scl_e[0] = 1'b1; push(K_SCL, 0, 1'b0, k + 5);
        wait_cyc(10);
        tb_sda_low[0] = 1'b1; wait_cyc(2); tb_sda_low[0] = 1'b0;
        wait_cyc(10);
        k = cyc; tb_sda_low[0] = 1'b1;
        push(K_SDA, 0, 1'b0, k + 5);
        push(K_SDA, 0, 1'b1, k + 8);
        wait_cyc(3); tb_sda_low[0] = 1'b0;
        wait_cyc(10);
        k = cyc; scl_e[0] = 1'b0; push(K_SCL, 0, 1'b1, k + 5);
        wait_cyc(10);

        // START and STOP driven by the master itself.
        k = cyc; sda_e[0] = 1'b1;
        push(K_SDA, 0, 1'b0, k + 5); push(K_START, 0, 1'b1, k + 6); push(K_BUSY, 0, 1'b1, k + 6);
        wait_cyc(10);
        k = cyc; sda_e[0] = 1'b0;
        push(K_SDA, 0, 1'b1, k + 5); push(K_STOP, 0, 1'b1, k + 6); push(K_BUSY, 0, 1'b0, k + 6);
        wait_cyc(10);

        // Both lines moving in the same cycle report nothing.
        k = cyc; scl_e[0] = 1'b1; sda_e[0] = 1'b1;
        push(K_SCL, 0, 1'b0, k + 5); push(K_SDA, 0, 1'b0, k + 5);
        wait_cyc(10);
        k = cyc; scl_e[0] = 1'b0; sda_e[0] = 1'b0;
        push(K_SCL, 0, 1'b1, k + 5); push(K_SDA, 0, 1'b1, k + 5);
        wait_cyc(10);

        // Clock stretching by another device.
        k = cyc; scl_e[0] = 1'b1; tb_scl_low[0] = 1'b1; push(K_SCL, 0, 1'b0, k + 5);
        wait_cyc(10);
        k = cyc; scl_e[0] = 1'b0; push(K_STR, 0, 1'b1, k + 5);
        wait_cyc(20);
        tb_scl_low[0] = 1'b0;
        push(K_SCL, 0, 1'b1, k + 25); push(K_STR, 0, 1'b0, k + 25);
        wait_cyc(10);

        // Arbitration: we release SDA while another master keeps it low.
        k = cyc; sda_e[0] = 1'b1;
        push(K_SDA, 0, 1'b0, k + 5); push(K_START, 0, 1'b1, k + 6); push(K_BUSY, 0, 1'b1, k + 6);
        wait_cyc(10);
        k = cyc; sda_e[0] = 1'b0; tb_sda_low[0] = 1'b1;
`ifdef I2C_IOBUF_ARB_DET_EN
        push(K_ARB, 0, 1'b1, k + 6);
`endif
        wait_cyc(12);
        k = cyc; scl_e[0] = 1'b1; push(K_SCL, 0, 1'b0, k + 5);
        wait_cyc(10);
        k = cyc; scl_e[0] = 1'b0; push(K_SCL, 0, 1'b1, k + 5);
`ifdef I2C_IOBUF_ARB_DET_EN
        push(K_ARB, 0, 1'b1, k + 7);
`endif
        wait_cyc(12);
        k = cyc; tb_sda_low[0] = 1'b0;
        push(K_SDA, 0, 1'b1, k + 5); push(K_STOP, 0, 1'b1, k + 6); push(K_BUSY, 0, 1'b0, k + 6);
        wait_cyc(10);

        // Channel 1 works on its own: short glitch rejected, long pull passes.
        tb_scl_low[1] = 1'b1; wait_cyc(2); tb_scl_low[1] = 1'b0;
        wait_cyc(10);
        k = cyc; scl_e[1] = 1'b1; push(K_SCL, 1, 1'b0, k + 5);
        wait_cyc(10);
        k = cyc; scl_e[1] = 1'b0; push(K_SCL, 1, 1'b1, k + 5);
        wait_cyc(15);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_events: got %0d still pending, required 0", exp_q.size());
            while (exp_q.size() != 0) begin
                ev_t e;
                e = exp_q.pop_front();
                $display("FAIL missing %s ch%0d: got none, required val=%0b at cyc %0d",
                         kname(e.kind), e.ch, e.val, e.cyc);
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
